// File: rtl/led_blink_core.sv
// Per-channel LED blinker driven by a 1 ms enable pulse, with half-periods
// programmed and read back over a chip-select register port.
module led_blink_core #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1ms,
  input  logic                cs,
  input  logic                write,
  input  logic                read,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [CNT_W-1:0]    wr_data,
  output logic [CNT_W-1:0]    rd_data,
  output logic [NUM_LEDS-1:0] led
);

  logic [CNT_W-1:0] period_all [NUM_LEDS];
  logic [CNT_W-1:0] rd_next;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             led_q;
    logic             wr_hit;

    // Out-of-range addresses never match any channel, so those writes drop.
    assign wr_hit = cs && write && (addr == ADDR_W'(g));

    always_ff @(posedge clk) begin
      if (!reset) begin
        period_q <= '0;
        cnt_q    <= '0;
        led_q    <= 1'b0;
      end else if (wr_hit) begin
        period_q <= wr_data;
        cnt_q    <= '0;
        led_q    <= 1'b0;
      end else if (tick_1ms) begin
        if (period_q == '0) begin
          cnt_q <= '0;
          led_q <= 1'b0;
        end else if (cnt_q >= period_q - CNT_W'(1)) begin
          cnt_q <= '0;
          led_q <= ~led_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign period_all[g] = period_q;
    assign led[g]        = led_q;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (addr == ADDR_W'(i)) rd_next = period_all[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (cs && read) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: doc/led_blink_core.md
Name: led_blink_core

Overview:
- Downstream consumer of the 1 kHz enable generator.
- Drives NUM_LEDS outputs, each blinking at its own programmable half-period in milliseconds.
- Periods are counted in 1 ms enable pulses; there are no derived clocks.
- Software programs and reads back periods through a simple chip-select register interface from the MMIO bus slot.

Parameters:
- NUM_LEDS, 4: number of independent blink channels (1..16).
- CNT_W, 16: width of the half-period register and the per-channel ms counter. Maximum half-period is 2^CNT_W-1 ms.
- ADDR_W, 4: register address width. Must satisfy 2^ADDR_W >= NUM_LEDS.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset; asserted when 0.
- tick_1ms  in  1  one-clk-wide enable pulse, once per ms, from the 1 kHz enable generator.
- cs  in  1  core select.
- write  in  1  write strobe; qualified by cs.
- read  in  1  read strobe; qualified by cs.
- addr  in  ADDR_W  channel index.
- wr_data  in  CNT_W  new half-period in ms.
- rd_data  out  CNT_W  read-back half-period, registered.
- led  out  NUM_LEDS  blink outputs; bit i belongs to channel i.

Behaviour:
- Reset: one clk with reset==0 clears every P[i] (period), C[i] (counter), led[i] and rd_data to 0. Reset overrides all other inputs, including a coincident tick or write.
- Per-channel state: P[i] (CNT_W bits), C[i] (CNT_W bits), led[i]. All updates occur only on posedge clk.
- Write: cs&&write with addr<NUM_LEDS loads P[addr]<=wr_data in the same edge. The same edge also clears C[addr]<=0 and led[addr]<=0, restarting the phase. Other channels are unaffected. Writes with addr>=NUM_LEDS are ignored.
- Read: cs&&read sets rd_data<=P[addr] on the next edge (1-cycle latency), or 0 if addr>=NUM_LEDS. rd_data holds its value when no read is issued.
- Counting, on a tick_1ms==1 edge for each channel not being written that edge:
  - P==0: channel disabled; C<=0, led<=0.
  - P!=0 and C>=P-1: C<=0, led<=~led.
  - Otherwise: C<=C+1.
- No tick: C and led hold.
- Timing: with P=N and no writes, led toggles on every Nth tick after the write. Full period is 2N ms. N=1 toggles on every tick.
- Period reduced below the current count: cannot leave C>P-1, because a write clears C. The >= compare is retained as a guard.
- Simultaneous write and tick to the same channel: the write wins. C=0, led=0, no toggle that edge. Ticks to other channels proceed normally.
- Simultaneous read and write to the same addr: rd_data returns the old P. The write is visible to a read on the following cycle.
- tick_1ms held high for several clks counts as one tick per clk. This is legal but out of spec for the generator.
- Counter arithmetic: unsigned, CNT_W bits. P=2^CNT_W-1 is legal; C never exceeds P-1, so it never wraps.
- Expected implementation: one always_ff per register group plus a generate loop over channels. Roughly 120-200 lines.

Test Plan:
- Reset/idle: hold reset=0 for 3 clks, then release and supply ticks every 10 clks for 50 ticks -> led==0, rd_data==0 throughout.
- Basic blink: write P[0]=3, then 12 ticks -> led[0] rises on tick 3, falls on tick 6, rises on 9, falls on 12. led[3:1] stay 0.
- Independent channels: P[0]=1, P[1]=2, P[2]=5, P[3]=0, 20 ticks:
  - led[0] toggles every tick.
  - led[1] toggles every 2nd tick.
  - led[2] toggles on ticks 5, 10, 15, 20.
  - led[3] stays 0.
- Write collides with tick: with P[1]=2 and led[1]=1, write P[1]=4 on the same clk as a tick -> led[1]=0 and C[1]=0 that edge, next toggle lands exactly 4 ticks later. Other channels are unchanged.
- Read-back and range:
  - Write P[2]=0xBEEF, read addr 2 -> rd_data==0xBEEF one clk later.
  - With NUM_LEDS=3 overridden, writing addr 3 has no effect and a read of addr 3 returns 0.
- Reset mid-operation: while channels blink, assert reset=0 for 1 clk coincident with a tick and a write -> all P, C, led and rd_data are 0 after that edge. With no new writes, no toggles follow.
